treasure_rx: RTL and testbench
==============================

Name: treasure_rx

Overview:
- Serial receiver for the treasure link; the receiving end of the FPGA treasure transmitter, on the Arduino-facing side of the bench FPGA build.
- Recovers 12-bit treasure frames at 9600 baud from a 50 MHz clock and decodes the 7-bit code into colour and shape.
- Presents each decoded result as a one-cycle VALID strobe with held COLOR/SHAPE.
- Flags malformed frames and unknown codes on FRAME_ERR.

Parameters:
- CLKS_PER_BIT, 5208: CLK cycles per bit; 50 MHz / 9600.
- HALF_BIT, CLKS_PER_BIT/2: integer-divided offset from the detected falling edge to the first mid-bit sample.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- SERIAL_IN  in  1  serial line; idles high; asynchronous to CLK.
- VALID  out  1  one-cycle pulse: a good frame was decoded.
- COLOR  out  2  11 blue, 10 red, 00 none; held from the last VALID.
- SHAPE  out  2  01 square, 10 triangle, 11 diamond, 00 none; held from the last VALID.
- FRAME_ERR  out  1  one-cycle pulse: bad preamble or trailer, or unknown code.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Frame on the wire is MSB first: 1,0,1, code[6:0], 0,1. The leading 1 cannot be told apart from idle, so sync is on the 1→0 edge.
- SERIAL_IN passes through a 2-flop synchronizer; all logic uses the synchronized value s. The synchronizer flops reset to 1.
- Reset values: VALID=0, FRAME_ERR=0, COLOR=00, SHAPE=00, BUSY=0, state=IDLE, counters=0.
- Bit timer: loaded with HALF_BIT-1 on edge detect, then reloaded with CLKS_PER_BIT-1 after each sample. A sample is taken when the timer reaches 0.
- States and transitions:
  - IDLE: on s falling (prev=1, now 0) → START.
  - START: at the mid-bit sample, s=0 → PRE_HI; s=1 → IDLE (glitch, no error).
  - PRE_HI: sample 1 → CODE with bit count 7; sample 0 → ERR.
  - CODE: shift the sample into code, MSB first; after the 7th sample → TRAIL.
  - TRAIL: sample 0 → STOP; sample 1 → ERR.
  - STOP: sample 1 → decode; known code → VALID; unknown code → ERR. Sample 0 → ERR.
  - ERR: pulse FRAME_ERR once, then → RECOVER.
  - RECOVER: wait until s has been 1 continuously for CLKS_PER_BIT cycles → IDLE. Any 0 restarts the wait.
- Decode table:
  - Red (10): square 0011001, triangle 1011010, diamond 0110011.
  - Blue (11): square 1010101, triangle 0010110, diamond 1111111.
- VALID, COLOR and SHAPE update on the cycle after the stop-bit sample. Latency from the sync falling edge to VALID is HALF_BIT + 10*CLKS_PER_BIT + 1 cycles, plus 2 synchronizer cycles.
- After a good frame, STOP returns to IDLE immediately. A back-to-back falling edge in the second half of the stop bit must be caught.
- VALID and FRAME_ERR are never high in the same cycle.
- RESET_N low mid-frame aborts with no pulse; all outputs return to reset values asynchronously.

Optional Feature:
- Macro: TREASURE_RX_MAJORITY_EN.
- Defined: each bit value is the majority of 3 samples at mid-1, mid and mid+1. The timer schedule is unchanged; the decision is available at mid+1, so every output event shifts one cycle later.
- Undefined: single sample at mid-bit.

Decomposition:
- Package treasure_pkg holds:
  - COLOR_NONE/RED/BLUE and SHAPE_NONE/SQUARE/TRIANGLE/DIAMOND constants;
  - the six 7-bit code constants;
  - the 12-bit frame layout constants (PREAMBLE=3'b101, TRAILER=2'b01);
  - a state enum typedef.
- The transmitter imports the same package.
- One sub-module, treasure_bit_timer: the load/decrement counter producing the sample strobe. The FSM and decode live in treasure_rx.

Test Plan (CLKS_PER_BIT=16, HALF_BIT=8 unless noted):
- Idle line, then frame 101_1010101_01 → one VALID, COLOR=11, SHAPE=01, FRAME_ERR=0. VALID lands exactly 8+160+1+2 cycles after the line falls.
- All six codes sent back-to-back with zero idle gap → six VALIDs with the correct colour/shape each; no FRAME_ERR.
- A 4-cycle low glitch on an idle line → no VALID, no FRAME_ERR, BUSY back low by cycle 8+3.
- Trailer bits 11 instead of 01 → one FRAME_ERR; then a valid red diamond 0110011 after 16 idle cycles → VALID, COLOR=10, SHAPE=11.
- Code 0000000 → FRAME_ERR; COLOR/SHAPE keep their prior values.
- RESET_N pulsed low mid-CODE → outputs 0 immediately; the next full frame decodes correctly. With TREASURE_RX_MAJORITY_EN, a 1-cycle inverted spike at mid-bit still decodes correctly.

Source files
------------

// File: rtl/treasure_pkg.sv
// Shared constants, types and code decode for the treasure link (receiver and transmitter).
package treasure_pkg;

    localparam logic [1:0] COLOR_NONE = 2'b00;
    localparam logic [1:0] COLOR_RED  = 2'b10;
    localparam logic [1:0] COLOR_BLUE = 2'b11;

    localparam logic [1:0] SHAPE_NONE     = 2'b00;
    localparam logic [1:0] SHAPE_SQUARE   = 2'b01;
    localparam logic [1:0] SHAPE_TRIANGLE = 2'b10;
    localparam logic [1:0] SHAPE_DIAMOND  = 2'b11;

    localparam logic [6:0] CODE_RED_SQUARE    = 7'b0011001;
    localparam logic [6:0] CODE_RED_TRIANGLE  = 7'b1011010;
    localparam logic [6:0] CODE_RED_DIAMOND   = 7'b0110011;
    localparam logic [6:0] CODE_BLUE_SQUARE   = 7'b1010101;
    localparam logic [6:0] CODE_BLUE_TRIANGLE = 7'b0010110;
    localparam logic [6:0] CODE_BLUE_DIAMOND  = 7'b1111111;

    // Wire order, MSB first: PREAMBLE, code[6:0], TRAILER.
    localparam int         FRAME_BITS = 12;
    localparam logic [2:0] PREAMBLE   = 3'b101;
    localparam logic [1:0] TRAILER    = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_PRE_HI,
        ST_CODE,
        ST_TRAIL,
        ST_STOP,
        ST_ERR,
        ST_RECOVER
    } rx_state_t;

    typedef struct packed {
        logic       known;
        logic [1:0] color;
        logic [1:0] shape;
    } decode_t;

    function automatic decode_t decode_code(input logic [6:0] code);
        decode_t d;
        d.known = 1'b1;
        d.color = COLOR_NONE;
        d.shape = SHAPE_NONE;
        case (code)
            CODE_RED_SQUARE:    begin d.color = COLOR_RED;  d.shape = SHAPE_SQUARE;   end
            CODE_RED_TRIANGLE:  begin d.color = COLOR_RED;  d.shape = SHAPE_TRIANGLE; end
            CODE_RED_DIAMOND:   begin d.color = COLOR_RED;  d.shape = SHAPE_DIAMOND;  end
            CODE_BLUE_SQUARE:   begin d.color = COLOR_BLUE; d.shape = SHAPE_SQUARE;   end
            CODE_BLUE_TRIANGLE: begin d.color = COLOR_BLUE; d.shape = SHAPE_TRIANGLE; end
            CODE_BLUE_DIAMOND:  begin d.color = COLOR_BLUE; d.shape = SHAPE_DIAMOND;  end
            default:            d.known = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/treasure_bit_timer.sv
// Bit timer: half-bit load on start edge, then full-bit reload; tick when the count reaches zero.
module treasure_bit_timer #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] HALF_LOAD = W'(HALF_BIT - 1);
    localparam logic [W-1:0] BIT_LOAD  = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= HALF_LOAD;
        end else if (en) begin
            cnt <= (cnt == '0) ? BIT_LOAD : cnt - W'(1);
        end
    end

    assign tick = en && !load && (cnt == '0);

endmodule

// File: rtl/treasure_rx.sv
// Treasure link receiver: 12-bit frame recovery, code decode, VALID/FRAME_ERR pulses.
// Build option TREASURE_RX_MAJORITY_EN: each bit is the 2-of-3 vote of samples at mid-1, mid, mid+1.
module treasure_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       SERIAL_IN,
    output logic       VALID,
    output logic [1:0] COLOR,
    output logic [1:0] SHAPE,
    output logic       FRAME_ERR,
    output logic       BUSY
);
    import treasure_pkg::*;

    // state      | meaning
    // IDLE       | line idle, waiting for the 1->0 edge into the start bit
    // START      | checking the start (0) bit at mid-bit; a 1 is a glitch
    // PRE_HI     | checking the preamble trailing 1
    // CODE       | shifting in 7 code bits, MSB first
    // TRAIL      | expecting trailer 0
    // STOP       | expecting trailer 1, then decode
    // ERR        | single-cycle FRAME_ERR pulse
    // RECOVER    | waiting for one full bit time of continuous 1

    localparam int RW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [RW-1:0] REC_LOAD = RW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_q;
    logic          s;
    logic          s_prev;
    logic          fall;
    logic          tick;
    logic          smp;
    logic          bit_val;
    logic          timer_load;
    logic          timer_en;

    rx_state_t     state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [6:0]    code, code_n;
    logic [RW-1:0] rec_cnt, rec_cnt_n;
    logic          valid_q, valid_n;
    logic [1:0]    color_q, color_n;
    logic [1:0]    shape_q, shape_n;
    decode_t       dec;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= 2'b11;
            s_prev <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], SERIAL_IN};
            s_prev <= s;
        end
    end

    assign s    = sync_q[1];
    assign fall = s_prev && !s;

`ifdef TREASURE_RX_MAJORITY_EN
    logic s_prev2;
    logic tick_d;

    // The vote needs the mid+1 sample, so the FSM acts one cycle after the timer tick.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s_prev2 <= 1'b1;
            tick_d  <= 1'b0;
        end else begin
            s_prev2 <= s_prev;
            tick_d  <= tick;
        end
    end

    assign smp     = tick_d;
    assign bit_val = (s & s_prev) | (s & s_prev2) | (s_prev & s_prev2);
`else
    assign smp     = tick;
    assign bit_val = s;
`endif

    assign timer_en = state inside {ST_START, ST_PRE_HI, ST_CODE, ST_TRAIL, ST_STOP};

    treasure_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .HALF_BIT     (HALF_BIT)
    ) u_timer (
        .clk   (CLK),
        .rst_n (RESET_N),
        .load  (timer_load),
        .en    (timer_en),
        .tick  (tick)
    );

    assign dec = decode_code(code);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            code    <= '0;
            rec_cnt <= '0;
            valid_q <= 1'b0;
            color_q <= COLOR_NONE;
            shape_q <= SHAPE_NONE;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            code    <= code_n;
            rec_cnt <= rec_cnt_n;
            valid_q <= valid_n;
            color_q <= color_n;
            shape_q <= shape_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        code_n     = code;
        rec_cnt_n  = rec_cnt;
        valid_n    = 1'b0;
        color_n    = color_q;
        shape_n    = shape_q;
        timer_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_n    = ST_START;
                    timer_load = 1'b1;
                end
            end
            ST_START: begin
                if (smp) state_n = (bit_val == PREAMBLE[1]) ? ST_PRE_HI : ST_IDLE;
            end
            ST_PRE_HI: begin
                if (smp) begin
                    if (bit_val == PREAMBLE[0]) begin
                        state_n   = ST_CODE;
                        bit_cnt_n = 3'd7;
                    end else begin
                        state_n = ST_ERR;
                    end
                end
            end
            ST_CODE: begin
                if (smp) begin
                    code_n    = {code[5:0], bit_val};
                    bit_cnt_n = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd1) state_n = ST_TRAIL;
                end
            end
            ST_TRAIL: begin
                if (smp) state_n = (bit_val == TRAILER[1]) ? ST_STOP : ST_ERR;
            end
            ST_STOP: begin
                // Back to IDLE at mid-stop so a following start edge is not missed.
                if (smp) begin
                    if (bit_val == TRAILER[0] && dec.known) begin
                        state_n = ST_IDLE;
                        valid_n = 1'b1;
                        color_n = dec.color;
                        shape_n = dec.shape;
                    end else begin
                        state_n = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                state_n   = ST_RECOVER;
                rec_cnt_n = REC_LOAD;
            end
            ST_RECOVER: begin
                if (!s) begin
                    rec_cnt_n = REC_LOAD;
                end else if (rec_cnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    rec_cnt_n = rec_cnt - RW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign VALID     = valid_q;
    assign COLOR     = color_q;
    assign SHAPE     = shape_q;
    assign FRAME_ERR = (state == ST_ERR);
    assign BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_treasure_rx.sv
// Self-checking bench for treasure_rx with a scoreboard of expected colour/shape per frame.
module tb_treasure_rx;

    localparam int CPB = 16;
    localparam int HB  = 8;
`ifdef TREASURE_RX_MAJORITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct packed {
        logic [1:0] color;
        logic [1:0] shape;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_in;
    logic       valid;
    logic [1:0] color;
    logic [1:0] shape;
    logic       frame_err;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   valid_cnt = 0;
    int   err_cnt = 0;
    int   last_valid_cyc = 0;
    exp_t exp_q[$];
    exp_t e;

    treasure_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB)) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .SERIAL_IN (serial_in),
        .VALID     (valid),
        .COLOR     (color),
        .SHAPE     (shape),
        .FRAME_ERR (frame_err),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic model_decode(input logic [6:0] code, output logic [1:0] c, output logic [1:0] sh);
        c  = 2'b00;
        sh = 2'b00;
        case (code)
            7'b0011001: begin c = 2'b10; sh = 2'b01; return 1'b1; end
            7'b1011010: begin c = 2'b10; sh = 2'b10; return 1'b1; end
            7'b0110011: begin c = 2'b10; sh = 2'b11; return 1'b1; end
            7'b1010101: begin c = 2'b11; sh = 2'b01; return 1'b1; end
            7'b0010110: begin c = 2'b11; sh = 2'b10; return 1'b1; end
            7'b1111111: begin c = 2'b11; sh = 2'b11; return 1'b1; end
            default:    return 1'b0;
        endcase
    endfunction

    // Scoreboard side: every VALID pops one expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid === 1'b1) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid got color=%b shape=%b want no VALID", color, shape);
                end else begin
                    e = exp_q.pop_front();
                    if ({color, shape} !== {e.color, e.shape}) begin
                        errors++;
                        $display("FAIL decode got color=%b shape=%b want color=%b shape=%b",
                                 color, shape, e.color, e.shape);
                    end
                end
            end
            if (frame_err === 1'b1) err_cnt++;
            if (valid === 1'b1 && frame_err === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL valid_and_err got both high want at most one");
            end
        end
    end

    task automatic drive_bit(input logic b, input logic spike);
        serial_in = b;
        if (spike) begin
            repeat (8) @(posedge clk);
            #1 serial_in = ~b;
            @(posedge clk);
            #1 serial_in = b;
            repeat (7) @(posedge clk);
            #1;
        end else begin
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [6:0] code, input logic [1:0] trailer, input int spike_bit);
        logic [11:0] f;
        f = {3'b101, code, trailer};
        for (int i = 11; i >= 0; i--) drive_bit(f[i], (11 - i) == spike_bit);
    endtask

    task automatic expect_frame(input logic [6:0] code);
        logic [1:0] c;
        logic [1:0] sh;
        if (model_decode(code, c, sh)) exp_q.push_back('{color: c, shape: sh});
    endtask

    task automatic wait_idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string name, input int v0, input int dv, input int e0, input int de);
        checks++;
        if (valid_cnt - v0 !== dv || err_cnt - e0 !== de) begin
            errors++;
            $display("FAIL %s got valid=%0d err=%0d want valid=%0d err=%0d",
                     name, valid_cnt - v0, err_cnt - e0, dv, de);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got %0d queued want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid, frame_err, color, shape, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b e=%b c=%b s=%b b=%b want all 0",
                     valid, frame_err, color, shape, busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle(4);
    endtask

    task automatic test_single_frame();
        int t0, v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        t0 = cyc;
        expect_frame(7'b1010101);
        send_frame(7'b1010101, 2'b01, -1);
        wait_idle(16);
        check_counts("single", v0, 1, e0, 0);
        checks++;
        if (last_valid_cyc - (t0 + CPB) !== HB + 10 * CPB + 1 + 2 + EXTRA) begin
            errors++;
            $display("FAIL latency got %0d want %0d", last_valid_cyc - (t0 + CPB), HB + 10 * CPB + 3 + EXTRA);
        end
        checks++;
        if (color !== 2'b11 || shape !== 2'b01) begin
            errors++;
            $display("FAIL single_hold got c=%b s=%b want c=11 s=01", color, shape);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] codes [6];
        int v0, e0;
        codes = '{7'b0011001, 7'b1011010, 7'b0110011, 7'b1010101, 7'b0010110, 7'b1111111};
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 6; i++) begin
            expect_frame(codes[i]);
            send_frame(codes[i], 2'b01, -1);
        end
        wait_idle(32);
        check_counts("back_to_back", v0, 6, e0, 0);
    endtask

    task automatic test_glitch();
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        serial_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 serial_in = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got %b want 1", busy); end
        repeat (6 + EXTRA) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_pre got %b want 1", busy); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b want 0", busy); end
        wait_idle(32);
        check_counts("glitch", v0, 0, e0, 0);
    endtask

    task automatic test_bad_trailer();
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(7'b1010101, 2'b11, -1);
        wait_idle(16);
        check_counts("bad_trailer", v0, 0, e0, 1);
        expect_frame(7'b0110011);
        send_frame(7'b0110011, 2'b01, -1);
        wait_idle(32);
        check_counts("after_err", v0, 1, e0, 1);
        checks++;
        if (color !== 2'b10 || shape !== 2'b11) begin
            errors++;
            $display("FAIL after_err_hold got c=%b s=%b want c=10 s=11", color, shape);
        end
    endtask

    task automatic test_unknown_code();
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(7'b0000000, 2'b01, -1);
        wait_idle(32);
        check_counts("unknown", v0, 0, e0, 1);
        checks++;
        if (color !== 2'b10 || shape !== 2'b11) begin
            errors++;
            $display("FAIL unknown_hold got c=%b s=%b want c=10 s=11", color, shape);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] f;
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        f = {3'b101, 7'b1010101, 2'b01};
        for (int i = 11; i >= 6; i--) drive_bit(f[i], 1'b0);
        serial_in = f[5];
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid, frame_err, color, shape, busy} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b e=%b c=%b s=%b b=%b want all 0",
                     valid, frame_err, color, shape, busy);
        end
        serial_in = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle(32);
        expect_frame(7'b0010110);
        send_frame(7'b0010110, 2'b01, -1);
        wait_idle(32);
        check_counts("after_reset", v0, 1, e0, 0);
        checks++;
        if (color !== 2'b11 || shape !== 2'b10) begin
            errors++;
            $display("FAIL after_reset_hold got c=%b s=%b want c=11 s=10", color, shape);
        end
    endtask

`ifdef TREASURE_RX_MAJORITY_EN
    task automatic test_spike();
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        expect_frame(7'b1111111);
        send_frame(7'b1111111, 2'b01, 5);
        expect_frame(7'b0110011);
        send_frame(7'b0110011, 2'b01, 3);
        wait_idle(32);
        check_counts("spike", v0, 2, e0, 0);
    endtask
`endif

    initial begin
        serial_in = 1'b1;
        rst_n     = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_bad_trailer();
        test_unknown_code();
        test_reset_mid_frame();
`ifdef TREASURE_RX_MAJORITY_EN
        test_spike();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
